// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic opcodes and default widths.
package alu_pkg;
  localparam int W_DEF     = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_XNOR  = 3'b011,
    OP_NOR   = 3'b100,
    OP_NAND  = 3'b101,
    OP_NOTX  = 3'b110,
    OP_PASSY = 3'b111
  } alu_op_e;
endpackage

// File: rtl/alu_logic_unit.sv
// Combinational bitwise logic unit, shared with the full ALU.
module alu_logic_unit
  import alu_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  output logic [W-1:0] res_o
);

  always_comb begin
    res_o = '0;
    unique case (alu_op_e'(op_i))
      OP_AND:   res_o = x_i & y_i;
      OP_OR:    res_o = x_i | y_i;
      OP_XOR:   res_o = x_i ^ y_i;
      OP_XNOR:  res_o = ~(x_i ^ y_i);
      OP_NOR:   res_o = ~(x_i | y_i);
      OP_NAND:  res_o = ~(x_i & y_i);
      OP_NOTX:  res_o = ~x_i;
      OP_PASSY: res_o = y_i;
    endcase
  end

endmodule

// File: rtl/alu_logic_pipe.sv
// Two-stage logic-unit pipe with valid/ready and status flags.
// Define ALU_LOGIC_PARITY_EN to add a registered parity output.
module alu_logic_pipe
  import alu_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
  output logic             zero,
  output logic             neg,
  output logic [CNT_W-1:0] ops_done
`ifdef ALU_LOGIC_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q;
  logic [W-1:0]     s1_x_q, s1_y_q;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     res_q;
  logic             zero_q, neg_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     res;
  logic             s2_adv, s1_adv, accept, deliver;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid_q && out_ready;

  alu_logic_unit #(.W(W)) u_unit (
    .op_i  (s1_op_q),
    .x_i   (s1_x_q),
    .y_i   (s1_y_q),
    .res_o (res)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    if (accept)
      s1_valid_d = 1'b1;
    else if (s1_adv)
      s1_valid_d = 1'b0;
    if (s2_adv)
      out_valid_d = s1_valid_q;
    // saturate rather than wrap
    if (deliver && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_op_q <= op;
        s1_x_q  <= x;
        s1_y_q  <= y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      if (s1_adv) begin
        res_q  <= res;
        zero_q <= (res == '0);
        neg_q  <= res[W-1];
      end
    end
  end

`ifdef ALU_LOGIC_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      par_q <= 1'b0;
    else if (s1_adv)
      par_q <= ^res;
  end

  assign parity = par_q;
`endif

  assign out_valid = out_valid_q;
  assign out       = res_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ops_done  = cnt_q;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Bench for alu_logic_pipe: queue-based reference model plus directed vectors.
module tb_alu_logic_pipe;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  x = '0;
  logic [W-1:0]  y = '0;
  logic          in_ready, out_valid, zero, neg;
  logic [W-1:0]  out;
  logic [CW-1:0] ops_done;
`ifdef ALU_LOGIC_PARITY_EN
  logic          parity;
`endif

  alu_logic_pipe #(.W(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .neg       (neg),
    .ops_done  (ops_done)
`ifdef ALU_LOGIC_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         n;
    logic         p;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] got[$];
  int           cnt_m = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  bit           stall_prev = 0;
  bit           saw_full = 0;
  logic [W-1:0] prev_out;
  logic         prev_z, prev_n;

  function automatic exp_t model(logic [2:0] o, logic [W-1:0] a,
                                 logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] r;
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a ^ b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a & b);
      3'd6: r = ~a;
      default: r = b;
    endcase
    e.r = r;
    e.z = (r == 0);
    e.n = r[W-1];
    e.p = ^r;
    return e;
  endfunction

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the queue model
  always @(negedge clk) begin
    if (!rst) begin
      chk("ops_done", W'(ops_done), W'(cnt_m));
      chk("in_ready", W'(in_ready), W'(q.size() < 2 || out_ready));
      if (out_valid && q.size() == 0)
        chk("spurious_valid", 1, 0);
      if (stall_prev) begin
        chk("stall_out", out, prev_out);
        chk("stall_zero", W'(zero), W'(prev_z));
        chk("stall_neg", W'(neg), W'(prev_n));
      end
      if (out_valid && out_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("out", out, e.r);
        chk("zero", W'(zero), W'(e.z));
        chk("neg", W'(neg), W'(e.n));
`ifdef ALU_LOGIC_PARITY_EN
        chk("parity", W'(parity), W'(e.p));
`endif
        got.push_back(out);
        if (cnt_m < MAX) cnt_m++;
      end
      if (in_valid && in_ready)
        q.push_back(model(op, x, y));
      if (!in_ready) saw_full = 1;
      stall_prev = out_valid && !out_ready;
      prev_out   = out;
      prev_z     = zero;
      prev_n     = neg;
    end
  end

  task automatic send(logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b);
    bit acc;
    int t;
    t = 0;
    in_valid = 1;
    op = o;
    x = a;
    y = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 50);
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", W'(q.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1;
    q.delete();
    got.delete();
    cnt_m = 0;
    stall_prev = 0;
    @(posedge clk);
    #2;
    rst = 0;
  endtask

  logic [W-1:0] sweep_exp [8];

  initial begin
    sweep_exp = '{32'h000F000F, 32'h0FFF0FFF, 32'h0FF00FF0, 32'hF00FF00F,
                  32'hF000F000, 32'hFFF0FFF0, 32'hF0F0F0F0, 32'h00FF00FF};

    // Reset values, then single XNOR with exact latency
    do_reset();
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_out", out, 0);
    chk("rst_zero", W'(zero), 0);
    chk("rst_neg", W'(neg), 0);
    chk("rst_ops_done", W'(ops_done), 0);
    chk("rst_in_ready", W'(in_ready), 1);
    out_ready = 1;
    send(3'b011, 32'hFFFF0000, 32'hFF00FF00);
    chk("lat_n1_valid", W'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_n2_valid", W'(out_valid), 1);
    chk("lat_n2_out", out, 32'hFF0000FF);
    chk("lat_n2_zero", W'(zero), 0);
    chk("lat_n2_neg", W'(neg), 1);
    @(posedge clk);
    #1;
    chk("single_ops_done", W'(ops_done), 1);

    // Opcode sweep, back to back
    got.delete();
    for (int i = 0; i < 8; i++)
      send(3'(i), 32'h0F0F0F0F, 32'h00FF00FF);
    drain();
    chk("sweep_count", W'(got.size()), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("sweep_op%0d", i), got[i], sweep_exp[i]);

    // Zero flag
    send(3'b010, 32'hDEADBEEF, 32'hDEADBEEF);
    drain();
    chk("zf_out", out, 0);
    chk("zf_zero", W'(zero), 1);
    chk("zf_neg", W'(neg), 0);
`ifdef ALU_LOGIC_PARITY_EN
    chk("zf_parity", W'(parity), 0);
`endif

    // Backpressure: out_ready low for cycles 3..8
    do_reset();
    out_ready = 1;
    saw_full = 0;
    fork
      for (int i = 1; i <= 5; i++)
        send(3'b111, 32'h0, W'(i) * 32'h11111111);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    chk("bp_saw_full", W'(saw_full), 1);
    chk("bp_count", W'(got.size()), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_res%0d", i), got[i], W'(i + 1) * 32'h11111111);
    chk("bp_ops_done", W'(ops_done), 5);

    // Asynchronous reset with two entries held
    do_reset();
    out_ready = 1;
    send(3'b001, 32'h12340000, 32'h00005678);
    send(3'b000, 32'hFFFFFFFF, 32'h80000001);
    drain();
    chk("mf_pre_ops", W'(ops_done), 2);
    out_ready = 0;
    send(3'b111, 32'h0, 32'hAAAA5555);
    send(3'b111, 32'h0, 32'h5555AAAA);
    @(posedge clk);
    #3;
    rst = 1;
    q.delete();
    got.delete();
    cnt_m = 0;
    stall_prev = 0;
    #1;
    chk("mf_out_valid", W'(out_valid), 0);
    chk("mf_out", out, 0);
    chk("mf_ops_done", W'(ops_done), 0);
    @(posedge clk);
    #2;
    rst = 0;
    out_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("mf_no_stale", W'(got.size()), 0);
    chk("mf_valid_after", W'(out_valid), 0);

    // Counter saturation at 2^CW-1
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 20; i++)
      send(3'b010, W'(i), 32'h0000FFFF);
    drain();
    chk("sat_count", W'(got.size()), 20);
    chk("sat_ops_done", W'(ops_done), 15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
